wb_stream_fifo: RTL and testbench
=================================

# wb_stream_fifo

Wishbone slave peripheral on the SoC's external WB output port. It sits directly downstream of the OBI-to-WB bridge and receives CPU stores to the external address window (`block_sel == 2'b11`). Words written to its DATA register are buffered in a FIFO and presented on a valid/ready stream port toward the waveform-generation fabric. Software monitors fill level, overflow and a level-threshold interrupt through status and control registers.

## Interface
- `DEPTH`, 16, FIFO depth in 32-bit words; power of two, 2..256
- `LW`, `$clog2(DEPTH)+1`, level/pointer width (derived localparam, not overridable)
- `clk_i`  in  1  single clock (WB and stream side share it)
- `rst_i`  in  1  asynchronous, active-high reset
- `wb_addr_i`  in  32  byte address; only `[3:2]` decoded, upper bits decoded upstream
- `wb_wdata_i`  in  32  write data
- `wb_rdata_o`  out  32  read data, valid while `wb_ack_o` is high
- `wb_wr_en_i`  in  1  1 = write
- `wb_byte_en_i`  in  4  byte selects
- `wb_stb_i`  in  1  strobe
- `wb_cyc_i`  in  1  cycle
- `wb_ack_o`  out  1  single-cycle acknowledge
- `m_tdata_o`  out  32  stream data (head of FIFO)
- `m_tvalid_o`  out  1  stream valid
- `m_tready_i`  in  1  stream ready
- `irq_o`  out  1  level-threshold interrupt, registered

## Operation
- Register map (word offset = `addr[3:2]`):
  - 0 DATA: write pushes all 32 bits, byte selects ignored; reads return 0.
  - 1 STATUS (RO): bit 0 empty, bit 1 full, bit 2 overflow (sticky), bits `[8+LW-1:8]` level.
  - 2 CTRL (RW): bit 0 CLEAR (write-1, self-clearing, reads 0), bit 1 ENABLE (reset 1), bits `[16+LW-1:16]` THRESH (reset 0). Honours `byte_en[0]` for bits 0–1 and `byte_en[2]` for THRESH.
  - 3 OVFCNT: see Configuration; otherwise reads 0.
- Writes to RO or undefined fields are ignored. Every access is acked, so there are no bus errors.
- Push:
  - A DATA write accepted while not full stores the word at `wr_ptr` and increments `wr_ptr` (LW bits, wraps naturally).
  - A DATA write while full is dropped, sets overflow and is still acked.
- Pop:
  - `m_tvalid_o = !empty && ENABLE`.
  - A handshake (`m_tvalid_o && m_tready_i`) at a rising edge advances `rd_ptr`.
  - `m_tdata_o = mem[rd_ptr]`, show-ahead.
- Level: `wr_ptr - rd_ptr`, LW bits.
  - full = `level == DEPTH`; empty = `level == 0`.
- Full and empty are evaluated from state at the start of the cycle:
  - A push while full is dropped even if a pop happens in the same cycle.
  - A pop while empty cannot occur, because valid is low.
  - Push and pop together when neither full nor empty: level unchanged.
- CLEAR:
  - Sets `rd_ptr = wr_ptr = 0` and clears overflow.
  - Takes priority over any simultaneous stream pop.
  - Does not alter ENABLE or THRESH.
- ENABLE = 0 holds data in the FIFO; pushes continue to be accepted.
- `irq_o` is registered: `(THRESH != 0) && (level >= THRESH)`, using the post-update level.

## Timing
- Reset values: `wb_ack_o` 0, `wb_rdata_o` 0, `m_tvalid_o` 0, `irq_o` 0, pointers 0, overflow 0, ENABLE 1, THRESH 0. Memory contents are not reset.
- Ack:
  - Registered: `ack <= stb && cyc && !ack`.
  - High for exactly one cycle, one cycle after `stb && cyc` is first seen.
  - A held strobe yields one ack every second cycle.
- Register side effects (push, CLEAR, CTRL update) commit on the same edge that raises ack.
- `wb_rdata_o` is registered on that edge and reflects state before the access's own side effects.
- Push-to-stream latency: `m_tvalid_o` rises in the cycle `wb_ack_o` is high, one edge after the strobe.
- `irq_o` updates one cycle after the level change.
- Reset asserted mid-transaction clears everything asynchronously and no ack is issued. The master must restart the cycle.
- `cyc` dropping before ack aborts the access with no side effects.

## Configuration
- `WB_STREAM_FIFO_OVFCNT_EN` defined:
  - Adds a 16-bit saturating counter of dropped DATA writes, readable at offset 3 in bits `[15:0]`.
  - Cleared by CLEAR and by reset; saturates at `16'hFFFF`.
- Undefined: no counter logic; offset 3 reads 0 and writes are ignored.

## Test plan
- Reset, then read STATUS → `0x00000001` (empty); CTRL reads `0x00000002`; `irq_o` = 0, `m_tvalid_o` = 0.
- `m_tready_i` = 0; write `0xA0..0xAF` to DATA (DEPTH = 16), then one more write `0xB0` → STATUS = `0x00001006` (level 16, full, overflow); OVFCNT = 1 when enabled. Assert ready → stream `0xA0..0xAF` in order, one per cycle, with no `0xB0`.
- Level 2 and ready held high; write DATA `0x55` → push and pop in the same cycle, level stays 2, ordering preserved.
- THRESH = 4 via CTRL write `0x00040002`; push 4 words → `irq_o` rises one cycle after the fourth ack; one pop → `irq_o` falls next cycle.
- Level 5 and ready high; write CTRL `0x00000003` (CLEAR) in the same cycle as a handshake → level 0, overflow 0, no further valid; ENABLE still 1.
- ENABLE = 0 with level 3 → `m_tvalid_o` stays 0 under ready; re-enable → three words drain. Assert `rst_i` mid-strobe → no ack, all outputs at reset values.

Source files
------------

// File: rtl/wb_stream_fifo.sv
// Wishbone-written word FIFO drained through a valid/ready stream port.
// Optional dropped-write counter at offset 3: define WB_STREAM_FIFO_OVFCNT_EN.
module wb_stream_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] wb_addr_i,
    input  logic [31:0] wb_wdata_i,
    output logic [31:0] wb_rdata_o,
    input  logic        wb_wr_en_i,
    input  logic [3:0]  wb_byte_en_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    output logic [31:0] m_tdata_o,
    output logic        m_tvalid_o,
    input  logic        m_tready_i,
    output logic        irq_o
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;
    localparam int unsigned AW = LW - 1;

    logic [LW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, thresh_q, thresh_d;
    logic          ovf_q, ovf_d, enable_q, enable_d, ack_q, ack_d, irq_q, irq_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   mem_q [DEPTH];

    logic [LW-1:0] level_c;
    logic          full_c, empty_c, access_c, push_c, push_ok_c, pop_c, clear_c, ctrl_wr_c;
    logic [31:0]   status_c, ctrl_c, ovf_rd_c, rd_mux_c;

`ifdef WB_STREAM_FIFO_OVFCNT_EN
    logic [15:0]   ovfcnt_q, ovfcnt_d;
    assign ovf_rd_c = 32'(ovfcnt_q);
`else
    assign ovf_rd_c = '0;
`endif

    // Full/empty come from state at the start of the cycle
    assign level_c   = wr_ptr_q - rd_ptr_q;
    assign full_c    = (level_c == LW'(DEPTH));
    assign empty_c   = (level_c == '0);
    assign access_c  = wb_stb_i && wb_cyc_i && !ack_q;
    assign push_c    = access_c && wb_wr_en_i && (wb_addr_i[3:2] == 2'd0);
    assign push_ok_c = push_c && !full_c;
    assign ctrl_wr_c = access_c && wb_wr_en_i && (wb_addr_i[3:2] == 2'd2);
    assign clear_c   = ctrl_wr_c && wb_byte_en_i[0] && wb_wdata_i[0];
    assign pop_c     = m_tvalid_o && m_tready_i;

    assign m_tvalid_o = !empty_c && enable_q;
    assign m_tdata_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign wb_ack_o   = ack_q;
    assign wb_rdata_o = rdata_q;
    assign irq_o      = irq_q;

    logic unused_c;
    assign unused_c = ^{wb_addr_i[31:4], wb_addr_i[1:0], wb_byte_en_i[3], wb_byte_en_i[1]};

    always_comb begin
        status_c          = '0;
        status_c[0]       = empty_c;
        status_c[1]       = full_c;
        status_c[2]       = ovf_q;
        status_c[8 +: LW] = level_c;
        ctrl_c            = '0;
        ctrl_c[1]         = enable_q;
        ctrl_c[16 +: LW]  = thresh_q;
        case (wb_addr_i[3:2])
            2'd1:    rd_mux_c = status_c;
            2'd2:    rd_mux_c = ctrl_c;
            2'd3:    rd_mux_c = ovf_rd_c;
            default: rd_mux_c = '0;
        endcase
    end

    // Next-state: pointers, sticky flags, control fields, bus response
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        enable_d = enable_q;
        thresh_d = thresh_q;
        rdata_d  = rdata_q;
        ack_d    = wb_stb_i && wb_cyc_i && !ack_q;
        irq_d    = (thresh_q != '0) && (level_c >= thresh_q);
`ifdef WB_STREAM_FIFO_OVFCNT_EN
        ovfcnt_d = ovfcnt_q;
`endif
        if (access_c) rdata_d = rd_mux_c;
        if (clear_c) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
`ifdef WB_STREAM_FIFO_OVFCNT_EN
            ovfcnt_d = '0;
`endif
        end else begin
            if (push_ok_c) wr_ptr_d = wr_ptr_q + LW'(1);
            if (pop_c)     rd_ptr_d = rd_ptr_q + LW'(1);
            if (push_c && full_c) begin
                ovf_d = 1'b1;
`ifdef WB_STREAM_FIFO_OVFCNT_EN
                if (ovfcnt_q != 16'hFFFF) ovfcnt_d = ovfcnt_q + 16'd1;
`endif
            end
        end
        if (ctrl_wr_c) begin
            if (wb_byte_en_i[0]) enable_d = wb_wdata_i[1];
            if (wb_byte_en_i[2]) thresh_d = wb_wdata_i[16 +: LW];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            enable_q <= 1'b1;
            thresh_q <= '0;
            rdata_q  <= '0;
            ack_q    <= 1'b0;
            irq_q    <= 1'b0;
`ifdef WB_STREAM_FIFO_OVFCNT_EN
            ovfcnt_q <= '0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            enable_q <= enable_d;
            thresh_q <= thresh_d;
            rdata_q  <= rdata_d;
            ack_q    <= ack_d;
            irq_q    <= irq_d;
`ifdef WB_STREAM_FIFO_OVFCNT_EN
            ovfcnt_q <= ovfcnt_d;
`endif
        end
    end

    // Storage is intentionally not reset
    always_ff @(posedge clk_i) begin
        if (push_ok_c) mem_q[wr_ptr_q[AW-1:0]] <= wb_wdata_i;
    end

endmodule

// File: tb/tb_wb_stream_fifo.sv
// Directed bench for wb_stream_fifo (DEPTH = 16) with hand-computed expectations.
module tb_wb_stream_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] wb_addr = '0, wb_wdata = '0, wb_rdata;
    logic        wb_we = 1'b0, wb_stb = 1'b0, wb_cyc = 1'b0, wb_ack;
    logic [3:0]  wb_be = '0;
    logic [31:0] m_tdata;
    logic        m_tvalid, m_tready = 1'b0, irq;

    int n_vec = 0;
    int n_err = 0;

    wb_stream_fifo #(.DEPTH(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .wb_addr_i(wb_addr), .wb_wdata_i(wb_wdata), .wb_rdata_o(wb_rdata),
        .wb_wr_en_i(wb_we), .wb_byte_en_i(wb_be), .wb_stb_i(wb_stb), .wb_cyc_i(wb_cyc),
        .wb_ack_o(wb_ack), .m_tdata_o(m_tdata), .m_tvalid_o(m_tvalid),
        .m_tready_i(m_tready), .irq_o(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One bus access; returns #1 after the acking edge
    task automatic wb_xfer(input logic we, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] be, output logic [31:0] rd);
        bit got;
        got = 1'b0;
        rd  = '0;
        if (wb_ack) idle(1);
        wb_we = we; wb_addr = addr; wb_wdata = data; wb_be = be;
        wb_stb = 1'b1; wb_cyc = 1'b1;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk);
            #1;
            if (wb_ack) begin
                got = 1'b1;
                rd  = wb_rdata;
            end
        end
        wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
        if (!got) chk("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        logic [31:0] dummy;
        wb_xfer(1'b1, addr, data, be, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] v;
        wb_xfer(1'b0, addr, 32'd0, 4'hF, v);
        chk(tag, v, exp);
    endtask

    logic [31:0] ack_seq;

    initial begin
        idle(3);
        rst = 1'b0;
        idle(1);
        chk("rst_ack", 32'(wb_ack), 32'd0);
        chk("rst_rdata", wb_rdata, 32'd0);
        chk("rst_valid", 32'(m_tvalid), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        rd_chk("rst_status", 32'h4, 32'h0000_0001);
        rd_chk("rst_ctrl", 32'h8, 32'h0000_0002);

        // Held strobe: ack every second edge
        idle(1);
        wb_addr = 32'h0; wb_we = 1'b0; wb_stb = 1'b1; wb_cyc = 1'b1;
        ack_seq = '0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            ack_seq[i] = wb_ack;
        end
        wb_stb = 1'b0; wb_cyc = 1'b0;
        chk("held_stb_acks", ack_seq, 32'h5);
        idle(1);

        // Fill to full, then one dropped write
        for (int i = 0; i < 16; i++) wr(32'h0, 32'hA0 + 32'(i), 4'h0);
        wr(32'h0, 32'hB0, 4'hF);
        rd_chk("full_status", 32'h4, 32'h0000_1006);
`ifdef WB_STREAM_FIFO_OVFCNT_EN
        rd_chk("ovfcnt", 32'hC, 32'h0000_0001);
`else
        rd_chk("ovfcnt", 32'hC, 32'h0000_0000);
`endif
        idle(1);
        m_tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_valid", 32'(m_tvalid), 32'd1);
            chk("drain_data", m_tdata, 32'hA0 + 32'(i));
            idle(1);
        end
        chk("drain_empty", 32'(m_tvalid), 32'd0);
        m_tready = 1'b0;
        rd_chk("ovf_sticky", 32'h4, 32'h0000_0005);
        wr(32'h8, 32'h0000_0003, 4'h1);
        rd_chk("clear_ovf", 32'h4, 32'h0000_0001);
        rd_chk("clear_ovfcnt", 32'hC, 32'h0000_0000);

        // Simultaneous push and pop at level 2
        wr(32'h0, 32'h11, 4'hF);
        wr(32'h0, 32'h22, 4'hF);
        idle(1);
        m_tready = 1'b1;
        wr(32'h0, 32'h55, 4'hF);
        m_tready = 1'b0;
        rd_chk("pushpop_status", 32'h4, 32'h0000_0200);
        chk("pushpop_head", m_tdata, 32'h22);
        idle(1);
        m_tready = 1'b1;
        chk("pushpop_d0", m_tdata, 32'h22);
        idle(1);
        chk("pushpop_d1", m_tdata, 32'h55);
        idle(1);
        chk("pushpop_empty", 32'(m_tvalid), 32'd0);
        m_tready = 1'b0;

        // Threshold interrupt
        wr(32'h8, 32'h0004_0002, 4'hF);
        for (int i = 0; i < 3; i++) wr(32'h0, 32'h60 + 32'(i), 4'hF);
        chk("irq_lvl3", 32'(irq), 32'd0);
        wr(32'h0, 32'h63, 4'hF);
        chk("irq_at_ack", 32'(irq), 32'd0);
        idle(1);
        chk("irq_rise", 32'(irq), 32'd1);
        m_tready = 1'b1;
        idle(1);
        m_tready = 1'b0;
        chk("irq_hold", 32'(irq), 32'd1);
        idle(1);
        chk("irq_fall", 32'(irq), 32'd0);

        // CLEAR concurrent with a handshake at level 5
        wr(32'h0, 32'h64, 4'hF);
        wr(32'h0, 32'h65, 4'hF);
        idle(1);
        m_tready = 1'b1;
        wr(32'h8, 32'h0000_0003, 4'h1);
        chk("clr_valid", 32'(m_tvalid), 32'd0);
        idle(1);
        chk("clr_valid2", 32'(m_tvalid), 32'd0);
        m_tready = 1'b0;
        rd_chk("clr_status", 32'h4, 32'h0000_0001);
        rd_chk("clr_ctrl", 32'h8, 32'h0004_0002);
        chk("clr_irq", 32'(irq), 32'd0);
        wr(32'h8, 32'h0000_0002, 4'hF);

        // ENABLE = 0 holds data; THRESH untouched when byte 2 not selected
        wr(32'h8, 32'h0007_0000, 4'h1);
        rd_chk("dis_ctrl", 32'h8, 32'h0000_0000);
        for (int i = 0; i < 3; i++) wr(32'h0, 32'h31 + 32'(i), 4'hF);
        m_tready = 1'b1;
        idle(2);
        chk("dis_valid", 32'(m_tvalid), 32'd0);
        rd_chk("dis_status", 32'h4, 32'h0000_0300);
        idle(1);
        wr(32'h8, 32'h0000_0002, 4'h1);
        for (int i = 0; i < 3; i++) begin
            chk("en_valid", 32'(m_tvalid), 32'd1);
            chk("en_data", m_tdata, 32'h31 + 32'(i));
            idle(1);
        end
        chk("en_empty", 32'(m_tvalid), 32'd0);
        m_tready = 1'b0;

        // Reset mid-strobe
        wr(32'h0, 32'h77, 4'hF);
        wr(32'h8, 32'h0001_0002, 4'hF);
        idle(2);
        chk("pre_rst_valid", 32'(m_tvalid), 32'd1);
        chk("pre_rst_irq", 32'(irq), 32'd1);
        wb_we = 1'b1; wb_addr = 32'h0; wb_wdata = 32'h88; wb_be = 4'hF;
        wb_stb = 1'b1; wb_cyc = 1'b1;
        #3 rst = 1'b1;
        #1;
        chk("rst_mid_ack", 32'(wb_ack), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_mid_ack2", 32'(wb_ack), 32'd0);
        chk("rst_mid_valid", 32'(m_tvalid), 32'd0);
        chk("rst_mid_irq", 32'(irq), 32'd0);
        chk("rst_mid_rdata", wb_rdata, 32'd0);
        wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
        rst = 1'b0;
        idle(1);
        rd_chk("post_rst_status", 32'h4, 32'h0000_0001);
        rd_chk("post_rst_ctrl", 32'h8, 32'h0000_0002);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
